// File: rtl/if_stage_if.sv
// Port bundle between the instruction fetch stage and its surroundings:
// control from the core, the loader write port, and the decode-side outputs.
interface if_stage_if #(
  parameter int IMEM_AW = 12
);
  logic                 cpu_start;
  logic                 cpu_stop;
  logic [31:2]          start_adr;
  logic                 jmp_condition_ex;
  logic [31:2]          jmp_adr_ex;
  logic                 stall;
  logic                 rst_pipe;
  logic [IMEM_AW+1:2]   i_ram_wadr;
  logic [31:0]          i_ram_wdata;
  logic                 i_ram_wen;
  logic [31:0]          inst_id;
  logic [31:2]          pc_id;
  logic [31:0]          fetch_cnt;

  modport master (
    output cpu_start, cpu_stop, start_adr, jmp_condition_ex, jmp_adr_ex,
           stall, rst_pipe, i_ram_wadr, i_ram_wdata, i_ram_wen,
    input  inst_id, pc_id, fetch_cnt
  );

  modport slave (
    input  cpu_start, cpu_stop, start_adr, jmp_condition_ex, jmp_adr_ex,
           stall, rst_pipe, i_ram_wadr, i_ram_wdata, i_ram_wen,
    output inst_id, pc_id, fetch_cnt
  );
endinterface

// File: rtl/if_stage.sv
// RV32I instruction fetch stage: PC, IDLE/RUN control and synchronous instruction RAM.
// Optional delivered-instruction counter enabled by defining IF_FETCH_COUNTER_EN.
module if_stage #(
  parameter int IMEM_AW = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  if_stage_if.slave  bus
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state_reg;
  logic [31:2]         pc_if_reg;
  logic [31:2]         pc_next;
  logic                valid_if_reg;
  logic [31:0]         ram_q;
  logic [IMEM_AW-1:0]  ram_radr;
  logic [31:0]         mem [0:(1<<IMEM_AW)-1];

  always_comb begin
    pc_next = pc_if_reg;
    if (bus.rst_pipe) begin
      pc_next = bus.start_adr;
    end else if (state_reg == IDLE) begin
      if (bus.cpu_start) begin
        pc_next = bus.start_adr;
      end
    end else if (bus.stall) begin
      pc_next = pc_if_reg;
    end else if (bus.jmp_condition_ex) begin
      pc_next = bus.jmp_adr_ex;
    end else begin
      pc_next = pc_if_reg + 30'd1;
    end
  end

  // Upper PC bits are dropped here, so the RAM aliases across the address space.
  assign ram_radr = pc_next[IMEM_AW+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pc_if_reg    <= '0;
      valid_if_reg <= 1'b0;
    end else begin
      pc_if_reg <= pc_next;
      if (bus.rst_pipe) begin
        state_reg    <= IDLE;
        valid_if_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (bus.cpu_start) begin
              state_reg    <= RUN;
              valid_if_reg <= 1'b1;
            end else begin
              valid_if_reg <= 1'b0;
            end
          end
          RUN: begin
            if (bus.cpu_stop) begin
              state_reg    <= IDLE;
              valid_if_reg <= 1'b0;
            end
          end
          default: begin
            state_reg    <= IDLE;
            valid_if_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  // No reset on the RAM path so it maps onto block RAM; the old word is read on a same-address write.
  always_ff @(posedge clk) begin
    ram_q <= mem[ram_radr];
    if (bus.i_ram_wen) begin
      mem[bus.i_ram_wadr] <= bus.i_ram_wdata;
    end
  end

  assign bus.inst_id = valid_if_reg ? ram_q : NOP;
  assign bus.pc_id   = pc_if_reg;

`ifdef IF_FETCH_COUNTER_EN
  logic [31:0] fetch_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_reg <= '0;
    end else if (state_reg == RUN && valid_if_reg && !bus.stall && !bus.rst_pipe) begin
      fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
    end
  end

  assign bus.fetch_cnt = fetch_cnt_reg;
`else
  assign bus.fetch_cnt = '0;
`endif

endmodule
